// File: rtl/mult_arbiter_if.sv
// Bundle of the client request/response and multiplier-side signals of mult_arbiter.
// slave is the arbiter's view; master is the clients-plus-multiplier view.
interface mult_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req0_ready;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_err;
  logic        err;
  logic        mul_start;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic        mul_reset;
  logic        mul_fim;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  mul_fim, mul_hi, mul_lo,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_hi, resp_lo, resp_err, err,
    output mul_start, mul_op1, mul_op2, mul_reset
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output mul_fim, mul_hi, mul_lo,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_hi, resp_lo, resp_err, err,
    input  mul_start, mul_op1, mul_op2, mul_reset
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter and sequencer for two clients sharing one 32-cycle Booth multiplier,
// with a watchdog that resets the multiplier if fim never returns.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 40
) (
  input logic           clock,
  input logic           reset,
  mult_arbiter_if.slave bus
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_t;

  state_t         r_state;
  state_t         w_state_d;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_fire;
  logic [WdW-1:0] r_wd;
  logic [WdW-1:0] w_wd_inc;
  logic           r_last_grant;
  logic [31:0]    r_op1;
  logic [31:0]    r_op2;
  logic           r_resp_id;
  logic [31:0]    r_resp_hi;
  logic [31:0]    r_resp_lo;
  logic           r_resp_err;
  logic           r_resp_valid;
  logic           r_err;
  logic           r_mul_start;
  logic           r_wd_pulse;

  // On a tie the client not granted last wins; r_last_grant resets to 1 so client 0 goes first.
  always_comb begin
    w_grant0  = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    w_grant1  = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    w_wd_inc  = r_wd + 1'b1;
    w_fire    = (r_state == StWait) & ~bus.mul_fim & (w_wd_inc == WdMax);
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_grant0 | w_grant1) w_state_d = StStart;
      StStart: if (bus.mul_fim) w_state_d = StWait;
      StWait:  if (bus.mul_fim | w_fire) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_wd         <= '0;
      r_last_grant <= 1'b1;
      r_op1        <= '0;
      r_op2        <= '0;
      r_resp_id    <= 1'b0;
      r_resp_hi    <= '0;
      r_resp_lo    <= '0;
      r_resp_err   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_mul_start  <= 1'b0;
      r_wd_pulse   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_mul_start  <= (w_state_d == StStart);
      r_resp_valid <= (w_state_d == StResp);
      r_wd_pulse   <= w_fire;
      if ((r_state == StIdle) && (w_grant0 | w_grant1)) begin
        r_last_grant <= w_grant1;
        r_resp_id    <= w_grant1;
        r_op1        <= w_grant1 ? bus.req1_a : bus.req0_a;
        r_op2        <= w_grant1 ? bus.req1_b : bus.req0_b;
      end
      if ((r_state == StStart) && bus.mul_fim) begin
        r_wd <= '0;
      end else if (r_state == StWait) begin
        r_wd <= w_wd_inc;
      end
      if (r_state == StWait) begin
        if (bus.mul_fim) begin
          r_resp_hi  <= bus.mul_hi;
          r_resp_lo  <= bus.mul_lo;
          r_resp_err <= 1'b0;
        end else if (w_fire) begin
          r_resp_hi  <= '0;
          r_resp_lo  <= '0;
          r_resp_err <= 1'b1;
          r_err      <= 1'b1;
        end
      end
    end
  end

  // Reset is synchronous, so the handshake outputs are gated to keep them quiet in a reset cycle.
  assign bus.req0_ready = (r_state == StIdle) & w_grant0 & ~reset;
  assign bus.req1_ready = (r_state == StIdle) & w_grant1 & ~reset;
  assign bus.mul_start  = r_mul_start & ~reset;
  assign bus.mul_reset  = reset | r_wd_pulse;
  assign bus.mul_op1    = r_op1;
  assign bus.mul_op2    = r_op2;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_hi    = r_resp_hi;
  assign bus.resp_lo    = r_resp_lo;
  assign bus.resp_err   = r_resp_err;
  assign bus.err        = r_err;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-cycle radix-2 Booth multiplier. It accepts multiply requests from two clients, latches the winner's operands and pulses the multiplier's `start`. It then waits for the multiplier's `fim` to return high, captures `hi`/`lo`, and returns a tagged one-cycle response. A watchdog recovers the multiplier if `fim` never returns.

## Interface
- `TIMEOUT`, default 40: maximum WAIT cycles before the watchdog fires; must be > 33.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  request from client 0/1; held until accepted.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32  multiplicand/multiplier operands (signed); stable while valid.
- `req0_ready`, `req1_ready`  out  1  one-cycle accept pulse.
- `resp_valid`  out  1  one-cycle result pulse.
- `resp_id`  out  1  client owning the response.
- `resp_hi`, `resp_lo`  out  32  64-bit signed product, held until next response.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = watchdog abort, product invalid (0).
- `err`  out  1  sticky watchdog flag, cleared only by `reset`.
- `mul_start`  out  1  to multiplier `start`.
- `mul_op1`, `mul_op2`  out  32  to multiplier operand1 (A) / operando2 (B).
- `mul_reset`  out  1  to multiplier `reset`.
- `mul_fim`  in  1  from multiplier: 1 = idle/done.
- `mul_hi`, `mul_lo`  in  32  from multiplier.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - If any `reqN_valid` is high, grant one request, pulse its `reqN_ready` this cycle, latch its operands into `mul_op1`/`mul_op2`, record `resp_id`, then go to START.
  - If both requests are high, grant the client that was not granted last.
  - `last_grant` resets to 1, so client 0 wins the first tie.
- START:
  - `mul_start`=1 (registered).
  - If `mul_fim`=1, go to WAIT and clear the watchdog counter.
  - If `mul_fim`=0, stay in START; this is illegal but tolerated.
- WAIT:
  - `mul_start`=0 and the watchdog increments each cycle.
  - If `mul_fim`=1, capture `mul_hi`/`mul_lo` into `resp_hi`/`resp_lo`, set `resp_err`=0, go to RESP.
  - Else, if the watchdog reaches `TIMEOUT`:
    - assert `mul_reset` for one cycle
    - set `err`=1
    - set `resp_err`=1, with `resp_hi`/`resp_lo`=0
    - go to RESP
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- `mul_op1`/`mul_op2` hold stable from START until the next grant.
- `mul_start` is never high outside START and never high while `reset` is high.
- `mul_reset` = `reset` OR the watchdog pulse.
- Reset values: state IDLE, all ready/valid/start/err/resp_err 0, `resp_*` 0, `mul_op*` 0, `last_grant` 1, watchdog counter 0.
- Reset mid-operation returns to IDLE next cycle and clears the multiplier through `mul_reset`. No response is issued for the aborted request; the requester re-requests.

## Timing
- Cycle 0: IDLE, accept pulse (`reqN_ready`).
- Cycle 1: START, `mul_start`=1; the multiplier loads on the edge ending cycle 1.
- Cycles 2–34: WAIT, with `mul_fim`=0 during cycles 2–33.
- Cycle 34: `mul_fim`=1; capture on the edge ending cycle 34.
- Cycle 35: RESP, `resp_valid`=1.
- Result: accept-to-response latency 35 cycles; next accept possible at cycle 36, so one operation per 36 cycles.
- A `req` that arrives while the arbiter is busy waits; ready is never asserted outside IDLE.
- `reqN_ready` is combinational from state and `reqN_valid`. All other outputs are registered.

## Test plan
- Single request: client 0 sends A=3, B=5 -> `req0_ready` pulses at cycle 0, `resp_valid` at cycle 35 with `resp_id`=0, `{hi,lo}`=64'd15, `resp_err`=0.
- Signed operands: client 1 sends A=-7 (32'hFFFFFFF9), B=6 -> `resp_id`=1, `{hi,lo}`=64'hFFFFFFFF_FFFFFFD6 (-42). Also A=32'h80000000, B=32'h80000000 -> 64'h40000000_00000000.
- Contention: both clients valid from reset -> client 0 accepted first, client 1 accepted at cycle 36, client 0 again at cycle 72 if still valid; responses are tagged 0, 1, 0.
- Watchdog: stub drives `mul_fim` low permanently after start -> at WAIT cycle 40, `mul_reset` pulses for one cycle; RESP follows with `resp_err`=1, products 0; `err` stays 1 until `reset`.
- Reset mid-operation: assert `reset` at cycle 10 of a WAIT -> all outputs at reset values next cycle, `mul_reset` high with `reset`, no `resp_valid`; a subsequent request completes normally with correct product.
- Hold check: a requester changes operands after `ready` -> the product reflects the latched operands; `mul_start` is observed high in exactly one cycle per operation.
